// File: rtl/lifo_arbiter.sv
// lifo_arbiter
//   Round-robin arbiter and sequencer in front of a single shared LIFO.
//   Two requesters issue push/pop transactions. The winner is granted, the
//   LIFO strobes are driven, the registered read path of the LIFO is waited
//   out, and popped data is returned to the winner. A push on full and a pop
//   on empty are rejected with err and produce no LIFO strobe.
//
// Parameters
//   WIDTH  data width (matches the LIFO)
//   DEPTH  LIFO depth (used only by the optional level counter)
//
// Ports
//   clock, reset                 clock; asynchronous active-low reset
//   req0/1, op0/1, wdata0/1      requests (op 1 = push, 0 = pop) and push data
//   gnt0/1, done0/1, err0/1      grant, completion pulse, rejection flag
//   rdata0/1                     popped data, held until that requester's next pop
//   lifo_wn, lifo_rn, lifo_din   LIFO strobes and write data
//   lifo_dout, lifo_full,
//   lifo_empty                   LIFO read data and status
//   level                        occupancy count, only with LIFO_ARB_LEVEL_EN
//
// Build option: define LIFO_ARB_LEVEL_EN to add the level port and counter.

module lifo_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             lifo_wn,
  output logic             lifo_rn,
  output logic [WIDTH-1:0] lifo_din,
  input  logic [WIDTH-1:0] lifo_dout,
  input  logic             lifo_full,
  input  logic             lifo_empty
`ifdef LIFO_ARB_LEVEL_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_WAIT,
    S_CAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;     // priority pointer: requester favoured on a tie
  logic             win_q, win_d;     // requester currently being served
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic             wn_q, wn_d;
  logic             rn_q, rn_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] rdata0_q, rdata0_d;
  logic [WIDTH-1:0] rdata1_q, rdata1_d;
  logic             sel;
  logic             sel_op;

`ifdef LIFO_ARB_LEVEL_EN
  localparam int LW = $clog2(DEPTH+1);
  logic [LW-1:0] level_q, level_d;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = '0;
    wn_d     = 1'b0;
    rn_d     = 1'b0;
    din_d    = din_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef LIFO_ARB_LEVEL_EN
    level_d  = level_q;
`endif
    // A lone requester wins outright; on a tie the pointer decides.
    sel    = (req0 && req1) ? ptr_q : req1;
    sel_op = sel ? op1 : op0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          win_d = sel;
          ptr_d = ~sel;
          gnt_d = sel ? 2'b10 : 2'b01;
          if (sel_op && !lifo_full) begin
            state_d = S_PUSH;
            wn_d    = 1'b1;
            din_d   = sel ? wdata1 : wdata0;
          end else if (!sel_op && !lifo_empty) begin
            state_d = S_POP;
            rn_d    = 1'b1;
          end else begin
            // Rejected: complete straight away, no LIFO strobe.
            state_d = S_DONE;
            done_d  = sel ? 2'b10 : 2'b01;
            err_d   = sel ? 2'b10 : 2'b01;
          end
        end
      end
      S_PUSH: begin
        state_d        = S_DONE;
        done_d[win_q]  = 1'b1;
`ifdef LIFO_ARB_LEVEL_EN
        if (level_q != LW'(DEPTH)) level_d = level_q + 1'b1;
`endif
      end
      S_POP: begin
        state_d = S_WAIT;
`ifdef LIFO_ARB_LEVEL_EN
        if (level_q != '0) level_d = level_q - 1'b1;
`endif
      end
      S_WAIT: begin
        // LIFO DATAOUT was updated by the read strobe one edge earlier.
        state_d = S_CAP;
        if (win_q) rdata1_d = lifo_dout;
        else       rdata0_d = lifo_dout;
      end
      S_CAP: begin
        state_d       = S_DONE;
        done_d[win_q] = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      win_q    <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      wn_q     <= 1'b0;
      rn_q     <= 1'b0;
      din_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef LIFO_ARB_LEVEL_EN
      level_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wn_q     <= wn_d;
      rn_q     <= rn_d;
      din_q    <= din_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef LIFO_ARB_LEVEL_EN
      level_q  <= level_d;
`endif
    end
  end

  assign gnt0     = gnt_q[0];
  assign gnt1     = gnt_q[1];
  assign done0    = done_q[0];
  assign done1    = done_q[1];
  assign err0     = err_q[0];
  assign err1     = err_q[1];
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign lifo_wn  = wn_q;
  assign lifo_rn  = rn_q;
  assign lifo_din = din_q;
`ifdef LIFO_ARB_LEVEL_EN
  assign level    = level_q;
`endif

endmodule

// File: tb/tb_lifo_arbiter.sv
// Testbench for lifo_arbiter: a behavioural 8-deep LIFO sits behind the DUT,
// a driver issues rounds of requests and predicts each completion into a
// scoreboard, and a monitor checks every done pulse against it.

module tb_lifo_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [WIDTH-1:0] wdata0 = '0, wdata1 = '0;
  logic             gnt0, gnt1, done0, done1, err0, err1;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic             lifo_wn, lifo_rn;
  logic [WIDTH-1:0] lifo_din;
  logic [WIDTH-1:0] lifo_dout;
  logic             lifo_full, lifo_empty;
`ifdef LIFO_ARB_LEVEL_EN
  logic [$clog2(DEPTH+1)-1:0] level;
`endif

  lifo_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .lifo_wn(lifo_wn), .lifo_rn(lifo_rn), .lifo_din(lifo_din),
    .lifo_dout(lifo_dout), .lifo_full(lifo_full), .lifo_empty(lifo_empty)
`ifdef LIFO_ARB_LEVEL_EN
    , .level(level)
`endif
  );

  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural LIFO with a registered read port, sharing the DUT reset.
  logic [WIDTH-1:0] mem [DEPTH];
  int sp;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp        <= 0;
      lifo_dout <= '0;
    end else if (lifo_wn && sp < DEPTH) begin
      mem[sp] <= lifo_din;
      sp      <= sp + 1;
    end else if (lifo_rn && sp > 0) begin
      lifo_dout <= mem[sp-1];
      sp        <= sp - 1;
    end
  end
  assign lifo_full  = (sp == DEPTH);
  assign lifo_empty = (sp == 0);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: stack contents, round-robin pointer, held rdata.
  logic [WIDTH-1:0] stk [$];
  bit               ptr = 1'b0;
  logic [WIDTH-1:0] last_rd [2] = '{8'd0, 8'd0};
  int exp_wn = 0, exp_rn = 0, seen_wn = 0, seen_rn = 0, overlap = 0;

  typedef struct {
    int               id;
    bit               err;
    logic [WIDTH-1:0] data;
    longint           cyc;
  } sb_t;
  sb_t sb [$];

  task automatic model_reset();
    stk.delete();
    sb.delete();
    ptr        = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    req0  = 1'b0;
    req1  = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // One round: raise the chosen requests, predict service order and results,
  // hold each request until its done pulse.
  task automatic round(input bit r0, input bit o0, input logic [WIDTH-1:0] d0,
                       input bit r1, input bit o1, input logic [WIDTH-1:0] d1);
    int     order [$];
    longint e0;
    sb_t    e;
    int     budget;
    @(negedge clock);
    if (r0 && r1) begin
      order.push_back(ptr ? 1 : 0);
      order.push_back(ptr ? 0 : 1);
    end else if (r0) order.push_back(0);
    else if (r1)     order.push_back(1);
    e0 = cyc + 1;
    foreach (order[j]) begin
      int               w;
      bit               op;
      logic [WIDTH-1:0] d;
      longint           k;
      w     = order[j];
      op    = (w == 1) ? o1 : o0;
      d     = (w == 1) ? d1 : d0;
      e.id  = w;
      e.err = 1'b0;
      k     = 0;
      if (op) begin
        if (stk.size() >= DEPTH) e.err = 1'b1;
        else begin stk.push_back(d); exp_wn++; k = 1; end
      end else begin
        if (stk.size() == 0) e.err = 1'b1;
        else begin last_rd[w] = stk.pop_back(); exp_rn++; k = 3; end
      end
      e.data = last_rd[w];
      e.cyc  = e0 + k;
      sb.push_back(e);
      e0  = e0 + (e.err ? 64'd2 : (op ? 64'd3 : 64'd5));
      ptr = (w == 0);
    end
    req0 = r0; op0 = o0; wdata0 = d0;
    req1 = r1; op1 = o1; wdata1 = d1;
    budget = 0;
    while ((req0 || req1) && budget < 40) begin
      @(negedge clock);
      budget++;
      if (done0) req0 = 1'b0;
      if (done1) req1 = 1'b0;
    end
    chk("round_timeout", {62'd0, req0, req1}, 64'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    chk("sb_drained", sb.size(), 0);
    sb.delete();
`ifdef LIFO_ARB_LEVEL_EN
    chk("level_track", level, stk.size());
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"},  {gnt1, gnt0}, 0);
    chk({tag, "_done"}, {done1, done0}, 0);
    chk({tag, "_err"},  {err1, err0}, 0);
    chk({tag, "_wn"},   lifo_wn, 0);
    chk({tag, "_rn"},   lifo_rn, 0);
    chk({tag, "_rd0"},  rdata0, 0);
    chk({tag, "_rd1"},  rdata1, 0);
    chk({tag, "_din"},  lifo_din, 0);
`ifdef LIFO_ARB_LEVEL_EN
    chk({tag, "_level"}, level, 0);
`endif
  endtask

  // Monitor: strobe accounting and done-pulse checking against the scoreboard.
  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clock);
      if (lifo_wn) seen_wn++;
      if (lifo_rn) seen_rn++;
      if (lifo_wn && lifo_rn) overlap++;
      for (int i = 0; i < 2; i++) begin
        if ((i == 1) ? done1 : done0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done%0d actual=done required=idle", i);
          end else begin
            e = sb.pop_front();
            chk("done_id",    i, e.id);
            chk("done_cycle", cyc, e.cyc);
            chk("err",        (i == 1) ? err1 : err0, e.err);
            chk("rdata",      (i == 1) ? rdata1 : rdata0, e.data);
            chk("gnt_at_done", {gnt1, gnt0}, (i == 1) ? 2 : 1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int b;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Simultaneous pushes right after reset: requester 0 first.
    round(1, 1, 8'd40, 1, 1, 8'd70);
    round(1, 0, 8'd0, 0, 0, 8'd0);
    chk("pop_first_70", rdata0, 70);
    round(1, 0, 8'd0, 0, 0, 8'd0);
    chk("pop_second_40", rdata0, 40);

    // Reset while lifo_rn is high aborts the pop.
    round(1, 1, 8'h55, 0, 0, 8'd0);
    @(negedge clock);
    req0 = 1'b1; op0 = 1'b0;
    b = 0;
    while (!lifo_rn && b < 10) begin @(negedge clock); b++; end
    chk("rn_before_reset", lifo_rn, 1);
    #2 reset = 1'b0;
    exp_rn++;
    #1;
    check_reset_outputs("midpop");
    req0 = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    round(0, 0, 8'd0, 1, 1, 8'h77);

    // LIFO order across requesters.
    do_reset();
    round(1, 1, 8'd100, 0, 0, 8'd0);
    round(1, 1, 8'd150, 0, 0, 8'd0);
    round(1, 1, 8'd200, 0, 0, 8'd0);
    round(0, 0, 8'd0, 1, 0, 8'd0);
    chk("lifo_200", rdata1, 200);
    round(0, 0, 8'd0, 1, 0, 8'd0);
    chk("lifo_150", rdata1, 150);
    round(0, 0, 8'd0, 1, 0, 8'd0);
    chk("lifo_100", rdata1, 100);

    // Pop on empty is rejected and leaves rdata alone.
    round(0, 0, 8'd0, 1, 0, 8'd0);
    chk("empty_pop_rdata_held", rdata1, 100);

    // Fill to capacity, reject the ninth push, top is still 8.
    for (int v = 1; v <= 8; v++) round(1, 1, 8'(v), 0, 0, 8'd0);
    round(1, 1, 8'd9, 0, 0, 8'd0);
    round(0, 0, 8'd0, 1, 0, 8'd0);
    chk("full_top_8", rdata1, 8);

`ifdef LIFO_ARB_LEVEL_EN
    do_reset();
    for (int v = 0; v < 5; v++) round(1, 1, 8'(v + 10), 0, 0, 8'd0);
    round(0, 0, 8'd0, 1, 0, 8'd0);
    round(0, 0, 8'd0, 1, 0, 8'd0);
    chk("level_3", level, 3);
    do_reset();
    round(1, 0, 8'd0, 0, 0, 8'd0);
    chk("level_reject_0", level, 0);
`endif

    // Randomized rounds, push-biased so full and empty are both reached.
    do_reset();
    for (int n = 0; n < 250; n++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      round(sel != 1, $urandom_range(0, 9) < 6, 8'($urandom_range(0, 255)),
            sel != 0, $urandom_range(0, 9) < 6, 8'($urandom_range(0, 255)));
    end

    @(negedge clock);
    chk("wn_pulses", seen_wn, exp_wn);
    chk("rn_pulses", seen_rn, exp_rn);
    chk("strobe_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
